// File: rtl/multicycle_controller_pkg.sv
// mc_pkg: shared state enum, opcodes and datapath select encodings for the multi-cycle controller
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp, op[5], funct3 and funct7b5 to the 3-bit ALUControl
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  logic [2:0] w_funct;
  // subtract only for R-type with bit 30 set; immediate forms never subtract
  assign w_funct = funct3 == 3'b010 ? ALUC_SLT :
                   funct3 == 3'b110 ? ALUC_OR :
                   funct3 == 3'b111 ? ALUC_AND :
                   (funct3 == 3'b000 && op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
  assign alu_control = alu_op == ALUOP_SUB ? ALUC_SUB :
                       alu_op == ALUOP_FUNCT ? w_funct : ALUC_ADD;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM; MC_ILLEGAL_TRAP_EN adds a sticky TRAP state for unknown opcodes
module multicycle_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [31:0] instret,
  output logic        illegal_instr
);
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = TRAP;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif
  state_t      r_state, w_next;
  logic [31:0] r_instret;
  logic [1:0]  w_alu_op;
  logic        w_pc, w_ir, w_mem, w_reg, w_retire;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else r_state <= w_next;
  end
  // retired-instruction counter, bumped on every completing return to FETCH
  always_ff @(posedge clk) begin
    if (rst) r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end
  // next-state and Moore output decode
  always_comb begin
    w_next = r_state;
    w_alu_op = ALUOP_ADD;
    w_pc = 1'b0;
    w_ir = 1'b0;
    w_mem = 1'b0;
    w_reg = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RS2;
    case (r_state)
      FETCH: begin
        ResultSrc = RES_ALU;
        ALUSrcB = SRCB_FOUR;
        w_pc = mem_ready;
        w_ir = mem_ready;
        w_next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        w_next = (op == OP_LOAD || op == OP_STORE) ? MEMADR :
                 op == OP_OP ? EXECUTER :
                 op == OP_OPIMM ? EXECUTEI :
                 op == OP_BRANCH ? BEQ :
                 op == OP_JAL ? JAL : ILL_NEXT;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg = 1'b1;
        w_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mem = 1'b1;
        w_next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        w_alu_op = ALUOP_FUNCT;
        w_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next = ALUWB;
      end
      ALUWB: begin
        w_reg = 1'b1;
        w_next = FETCH;
      end
      BEQ: begin
        ALUSrcA = SRCA_RS1;
        w_alu_op = ALUOP_SUB;
        w_pc = zero;
        w_next = FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        w_pc = 1'b1;
        w_next = ALUWB;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      TRAP: w_next = TRAP;
`endif
      default: w_next = FETCH;
    endcase
  end
  assign w_retire = r_state == MEMWB || r_state == ALUWB || r_state == BEQ ||
                    (r_state == MEMWRITE && mem_ready);
  assign PCWrite = w_pc & ~rst;
  assign IRWrite = w_ir & ~rst;
  assign MemWrite = w_mem & ~rst;
  assign RegWrite = w_reg & ~rst;
  assign ImmSrc = op == OP_STORE ? IMM_S :
                  op == OP_BRANCH ? IMM_B :
                  op == OP_JAL ? IMM_J : IMM_I;
  assign instret = r_instret;
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = r_state == TRAP;
`else
  assign illegal_instr = 1'b0;
`endif
  alu_decoder u_alu_decoder (
    .alu_op(w_alu_op),
    .op5(op[5]),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .alu_control(ALUControl)
  );
endmodule
